// File: rtl/video_text_renderer.sv
// rtl/video_text_renderer.sv - 8x16 text-mode pixel pipeline with palette, char blink and cursor.
module video_text_renderer #(
    parameter int COLS         = 160,
    parameter int ROWS         = 45,
    parameter int ADDR_W       = 13,
    parameter int BLINK_FRAMES = 30,
    parameter bit HSYNC_ACTIVE = 1'b1,
    parameter bit VSYNC_ACTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       in_x,
    input  logic [15:0]       in_y,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_visible,
    output logic [ADDR_W-1:0] text_addr,
    input  logic [15:0]       text_data,
    output logic [11:0]       font_addr,
    input  logic [7:0]        font_data,
    input  logic [7:0]        cursor_col,
    input  logic [5:0]        cursor_row,
    input  logic              cursor_en,
    output logic [23:0]       out_rgb,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_visible
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);
    // Sync bundle layout: {hsync, vsync, visible}, kept at raw pin levels.
    localparam logic [2:0] SYNC_IDLE = {~HSYNC_ACTIVE, ~VSYNC_ACTIVE, 1'b0};

    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [7:0] lo;
        lo = idx[3] ? 8'h55 : 8'h00;
        if (idx == 4'd6)
            return 24'hAA5500;
        if (idx == 4'd14)
            return 24'hFFFF55;
        return {(idx[2] ? 8'hAA : 8'h00) + lo,
                (idx[1] ? 8'hAA : 8'h00) + lo,
                (idx[0] ? 8'hAA : 8'h00) + lo};
    endfunction

    logic [ADDR_W-1:0] text_addr_q, text_addr_d;
    logic [11:0]       font_addr_q;
    logic [3:0]        row1_q, row2_q;
    logic [2:0]        col1_q, col2_q, col3_q, col4_q;
    logic              cur1_q, cur2_q, cur3_q, cur4_q, cur1_d;
    logic [7:0]        attr3_q, attr4_q;
    logic [2:0]        sync1_q, sync2_q, sync3_q, sync4_q;
    logic [23:0]       rgb_q, rgb_d;
    logic [2:0]        sync5_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              blink_q, blink_d;
    logic              vs_prev_q;
    logic              vs_act;
    logic              pix_on;
    logic [12:0]       cell_col;
    logic [11:0]       cell_row;

    assign cell_col = in_x[15:3];
    assign cell_row = in_y[15:4];
    assign vs_act   = (in_vsync == VSYNC_ACTIVE);

    always_comb begin
        text_addr_d = ADDR_W'(32'(cell_row) * 32'(COLS) + 32'(cell_col));
        cur1_d = cursor_en
              && (cell_col == {5'b0, cursor_col}) && (32'(cell_col) < COLS)
              && (cell_row == {6'b0, cursor_row}) && (32'(cell_row) < ROWS)
              && (in_y[3:0] >= 4'd14);
    end

    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (vs_act && !vs_prev_q) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        // Bit 7 is the leftmost pixel, so column c selects bit 7-c == ~c.
        pix_on = font_data[~col4_q];
        if (attr4_q[7] && !blink_q)
            pix_on = 1'b0;
        if (cur4_q && blink_q)
            pix_on = 1'b1;
        rgb_d = 24'h0;
        if (sync4_q[0])
            rgb_d = pix_on ? palette(attr4_q[3:0]) : palette({1'b0, attr4_q[6:4]});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            text_addr_q <= '0;
            font_addr_q <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            col1_q      <= '0;
            col2_q      <= '0;
            col3_q      <= '0;
            col4_q      <= '0;
            cur1_q      <= 1'b0;
            cur2_q      <= 1'b0;
            cur3_q      <= 1'b0;
            cur4_q      <= 1'b0;
            attr3_q     <= '0;
            attr4_q     <= '0;
            sync1_q     <= SYNC_IDLE;
            sync2_q     <= SYNC_IDLE;
            sync3_q     <= SYNC_IDLE;
            sync4_q     <= SYNC_IDLE;
            sync5_q     <= SYNC_IDLE;
            rgb_q       <= '0;
            cnt_q       <= '0;
            blink_q     <= 1'b0;
            // Tracking the live level keeps a vsync held across reset from counting.
            vs_prev_q   <= vs_act;
        end else begin
            text_addr_q <= text_addr_d;
            row1_q      <= in_y[3:0];
            col1_q      <= in_x[2:0];
            cur1_q      <= cur1_d;
            sync1_q     <= {in_hsync, in_vsync, in_visible};

            row2_q      <= row1_q;
            col2_q      <= col1_q;
            cur2_q      <= cur1_q;
            sync2_q     <= sync1_q;

            font_addr_q <= {text_data[7:0], row2_q};
            attr3_q     <= text_data[15:8];
            col3_q      <= col2_q;
            cur3_q      <= cur2_q;
            sync3_q     <= sync2_q;

            attr4_q     <= attr3_q;
            col4_q      <= col3_q;
            cur4_q      <= cur3_q;
            sync4_q     <= sync3_q;

            rgb_q       <= rgb_d;
            sync5_q     <= sync4_q;

            cnt_q       <= cnt_d;
            blink_q     <= blink_d;
            vs_prev_q   <= vs_act;
        end
    end

    assign text_addr   = text_addr_q;
    assign font_addr   = font_addr_q;
    assign out_rgb     = rgb_q;
    assign out_hsync   = sync5_q[2];
    assign out_vsync   = sync5_q[1];
    assign out_visible = sync5_q[0];

endmodule

// File: tb/tb_video_text_renderer.sv
// tb/tb_video_text_renderer.sv - directed bench for video_text_renderer with text RAM / font ROM models.
module tb_video_text_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_x, in_y;
    logic        in_hsync, in_vsync, in_visible;
    logic [12:0] text_addr;
    logic [15:0] text_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [7:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        cursor_en;
    logic [23:0] out_rgb;
    logic        out_hsync, out_vsync, out_visible;

    logic [15:0] tram [0:8191];
    logic [7:0]  from [0:4095];

    int total = 0;
    int bad   = 0;

    video_text_renderer dut (
        .clk(clk), .reset(reset),
        .in_x(in_x), .in_y(in_y),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_visible(in_visible),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .out_rgb(out_rgb), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_visible(out_visible)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        text_data <= tram[text_addr];
        font_data <= from[font_addr];
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pix(input int x, input int y, input logic vis);
        in_x       = 16'(x);
        in_y       = 16'(y);
        in_visible = vis;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic vs_pulses(input int n);
        repeat (n) begin
            in_vsync = 1'b1;
            step(1);
            in_vsync = 1'b0;
            step(1);
        end
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input logic vis,
                             input logic [23:0] exp);
        set_pix(x, y, vis);
        step(5);
        expect_eq(tag, 32'(out_rgb), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) tram[i] = 16'h0;
        for (int i = 0; i < 4096; i++) from[i] = 8'h0;
        tram[322] = 16'h1F41;
        tram[323] = 16'h1641;
        tram[324] = 16'h2C41;
        tram[325] = 16'h1F42;
        tram[326] = 16'h9F43;
        from[12'h413] = 8'h18;
        from[12'h423] = 8'hFF;
        from[12'h433] = 8'hFF;

        reset = 1'b1;
        in_hsync = 1'b0; in_vsync = 1'b0;
        set_pix(0, 0, 1'b0);
        cursor_col = 8'd0; cursor_row = 6'd0; cursor_en = 1'b0;
        step(3);
        expect_eq("rst_rgb", 32'(out_rgb), 32'h0);
        expect_eq("rst_hsync", 32'(out_hsync), 32'h0);
        expect_eq("rst_vsync", 32'(out_vsync), 32'h0);
        expect_eq("rst_visible", 32'(out_visible), 32'h0);
        expect_eq("rst_text_addr", 32'(text_addr), 32'h0);
        expect_eq("rst_font_addr", 32'(font_addr), 32'h0);
        reset = 1'b0;

        for (int c = 0; c < 160; c++) begin
            step(1);
            if (c == 104 || c == 105 || c == 144 || c == 145) begin
                expect_eq($sformatf("lat_hsync_c%0d", c), 32'(out_hsync), 32'(c >= 105 && c <= 144));
                expect_eq($sformatf("lat_vsync_c%0d", c), 32'(out_vsync), 32'(c >= 105 && c <= 144));
                expect_eq($sformatf("lat_visible_c%0d", c), 32'(out_visible), 32'(c >= 105 && c <= 144));
            end
            in_hsync   = (c >= 100 && c < 140);
            in_vsync   = (c >= 100 && c < 140);
            in_visible = (c >= 100 && c < 140);
        end
        in_hsync = 1'b0; in_vsync = 1'b0;
        pulse_reset();

        set_pix(17, 35, 1'b1);
        step(1);
        expect_eq("text_addr_17_35", 32'(text_addr), 32'd322);
        step(2);
        expect_eq("font_addr_17_35", 32'(font_addr), 32'h413);
        step(2);
        expect_eq("rgb_col1_off", 32'(out_rgb), 32'h0000AA);

        pix_check("rgb_fgF_on", 19, 35, 1'b1, 24'hFFFFFF);
        pix_check("rgb_bg1_off", 16, 35, 1'b1, 24'h0000AA);
        pix_check("rgb_fg6_on", 27, 35, 1'b1, 24'hAA5500);
        pix_check("rgb_fgC_on", 35, 35, 1'b1, 24'hFF5555);
        pix_check("rgb_bg2_off", 32, 35, 1'b1, 24'h00AA00);

        pix_check("blank_on_bit", 43, 35, 1'b0, 24'h0);
        pix_check("blank_col0", 40, 35, 1'b0, 24'h0);
        pix_check("unblank_on_bit", 43, 35, 1'b1, 24'hFFFFFF);

        pulse_reset();
        cursor_col = 8'd2; cursor_row = 6'd2; cursor_en = 1'b1;
        pix_check("cursor_phase0", 18, 46, 1'b1, 24'h0000AA);
        pix_check("blinkchar_phase0", 51, 35, 1'b1, 24'h0000AA);
        vs_pulses(29);
        pix_check("cursor_after29", 18, 46, 1'b1, 24'h0000AA);
        vs_pulses(1);
        pix_check("cursor_after30", 18, 46, 1'b1, 24'hFFFFFF);
        pix_check("blinkchar_after30", 51, 35, 1'b1, 24'hFFFFFF);
        pix_check("cursor_row13", 18, 45, 1'b1, 24'h0000AA);
        cursor_en = 1'b0;
        pix_check("cursor_disabled", 18, 46, 1'b1, 24'h0000AA);
        cursor_en = 1'b1;
        vs_pulses(30);
        pix_check("cursor_after60", 18, 46, 1'b1, 24'h0000AA);

        vs_pulses(30);
        in_hsync = 1'b1;
        pix_check("pre_reset_blinkchar", 51, 35, 1'b1, 24'hFFFFFF);
        reset = 1'b1;
        step(1);
        expect_eq("midrst_rgb", 32'(out_rgb), 32'h0);
        expect_eq("midrst_hsync", 32'(out_hsync), 32'h0);
        expect_eq("midrst_visible", 32'(out_visible), 32'h0);
        expect_eq("midrst_text_addr", 32'(text_addr), 32'h0);
        reset = 1'b0;
        step(4);
        expect_eq("resume4_visible", 32'(out_visible), 32'h0);
        expect_eq("resume4_rgb", 32'(out_rgb), 32'h0);
        step(1);
        expect_eq("resume5_visible", 32'(out_visible), 32'h1);
        expect_eq("resume5_hsync", 32'(out_hsync), 32'h1);
        expect_eq("resume5_rgb_phase0", 32'(out_rgb), 32'h0000AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_text_renderer.md
Name: video_text_renderer

Overview:
- Text-mode pixel generator directly downstream of the video timing generator.
- Consumes its x/y/hsync/vsync/visible outputs and fetches character codes from an external synchronous text RAM, then glyph rows from an external synchronous font ROM.
- Emits 24-bit RGB with hsync/vsync/visible re-aligned to the pixel data.
- Fixed 8x16 glyph cell; default 160x45 cells for 1280x720.

Parameters:
- COLS, 160, character cells per row.
- ROWS, 45, character rows per frame.
- ADDR_W, 13, text RAM address width; COLS*ROWS <= 2^ADDR_W.
- BLINK_FRAMES, 30, frames per blink half-period (>= 1).
- HSYNC_ACTIVE, 1, active level of in_hsync/out_hsync.
- VSYNC_ACTIVE, 1, active level of in_vsync/out_vsync.

Ports:
- clk  in  1  pixel clock (74.25 MHz).
- reset  in  1  synchronous, active-high.
- in_x  in  16  pixel column from timing generator.
- in_y  in  16  pixel line from timing generator.
- in_hsync  in  1  horizontal sync.
- in_vsync  in  1  vertical sync.
- in_visible  in  1  active-area flag.
- text_addr  out  ADDR_W  text RAM read address (registered).
- text_data  in  16  text RAM data, valid 1 cycle after address: [7:0] char code, [11:8] fg index, [14:12] bg index, [15] char blink.
- font_addr  out  12  font ROM address {char, glyph row[3:0]} (registered).
- font_data  in  8  font ROM data, valid 1 cycle after address; bit 7 = leftmost pixel.
- cursor_col  in  8  cursor cell column.
- cursor_row  in  6  cursor cell row.
- cursor_en  in  1  cursor enable.
- out_rgb  out  24  pixel {R,G,B}, 8 bits each.
- out_hsync  out  1  hsync delayed to match out_rgb.
- out_vsync  out  1  vsync delayed to match out_rgb.
- out_visible  out  1  visible delayed to match out_rgb.

Behaviour:
- Reset:
  - out_rgb=0, out_hsync=~HSYNC_ACTIVE, out_vsync=~VSYNC_ACTIVE, out_visible=0.
  - text_addr=0, font_addr=0; all pipeline registers cleared (syncs to inactive level).
  - frame counter=0, blink_phase=0.
  - Reset mid-frame abandons in-flight pixels; no partial pixel emerges afterwards.
- Pipeline, input sampled at edge E1 (cycle N):
  - E1: text_addr <= (in_y>>4)*COLS + (in_x>>3), truncated to ADDR_W; glyph row = in_y[3:0], pixel col = in_x[2:0].
  - E2: RAM samples the address.
  - E3: font_addr <= {text_data[7:0], row}; latch attribute and cursor-hit flag.
  - E4: ROM samples the address.
  - E5: outputs registered.
- Latency is exactly 5 cycles for out_rgb, out_hsync, out_vsync and out_visible. Sync pulse widths are preserved bit-for-bit.
- Address computed regardless of in_visible; values outside COLS/ROWS are don't-care but must not stall anything.
- Pixel on = font_data[7-col].
- char blink: if attr[15]=1 and blink_phase=0, pixel on is forced to 0.
- Cursor hit: cursor_en=1, cell column == cursor_col, cell row == cursor_row, glyph row >= 14, and blink_phase=1. A hit forces pixel on to 1. Cursor inputs are sampled at E1 and take effect immediately.
- Colour: out_rgb = palette(fg) if pixel on else palette(bg, intensity 0). out_rgb=0 whenever the delayed visible is 0.
- Palette index bits {I,R,G,B}: each component = (bit?0xAA:0) + (I?0x55:0).
  - Exception index 6 → 0xAA5500.
  - Exception index 14 → 0xFFFF55.
- Blink counter:
  - Increments on each in_vsync transition into the active level (edge detect on registered in_vsync).
  - On reaching BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase.
  - in_vsync held active across reset release does not count as an edge.

Test Plan:
- Latency: in_hsync active for 40 cycles from cycle 100 → out_hsync active cycles 105–144; same for vsync and visible.
- Addressing: in_x=17, in_y=35 at cycle N → text_addr=322 at N+1; with text_data=0x1F41 → font_addr=0x413 at N+3.
- Pixel colour: char 0x41, attr fg=0xF, bg=1, font_data=0x18, visible. in_x[2:0]=3 → out_rgb=0xFFFFFF; in_x[2:0]=0 → 0x0000AA; fg=6 pixel on → 0xAA5500.
- Blink/cursor: cursor (2,2) enabled, pixel at glyph row 14 with glyph bit 0. Output is bg for the first 29 vsync edges; fg after edge 30 (counter 0→29 wraps); bg again after edge 60. Char with attr[15]=1 is hidden before edge 30 and shown after.
- Blanking: in_visible=0 with glyph bits all 1 → out_rgb=0 at all positions.
- Reset mid-line: assert reset for 1 cycle during active area → next cycle all outputs at reset values; clean resumption 5 cycles after new inputs, blink_phase=0.
